// File: rtl/serial_tx_piso_pkg.sv
// Shared definitions for the serial link transmitter: FSM state encoding,
// line levels and a width helper for small counters.
package serial_tx_piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

    // Counters covering a single value still need one bit.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_piso_baud_tick_counter.sv
// Bit-period counter: tick marks the last enabled clock of each bit.
// clear holds the count at zero so a new frame starts on a fresh bit period.
module baud_tick_counter
    import serial_tx_piso_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = min1_clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clear || (cnt_q == CNT_LAST))
                cnt_d = '0;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && !clear && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in/serial-out frame transmitter: start bit, DATA_W bits LSB-first,
// stop bit, each held CLKS_PER_BIT enabled clocks. All outputs registered.
module serial_tx_piso
    import serial_tx_piso_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = min1_clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] shreg_shift;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;

    baud_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    assign shreg_shift = shreg_q >> 1;

    // A held tx_start is taken at the stop-bit boundary itself, so
    // back-to-back frames get exactly one stop bit and no idle gap.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    tx_d   = IDLE_LINE;
                    busy_d = 1'b0;
                    if (tx_start) begin
                        shreg_d   = tx_data;
                        bit_idx_d = '0;
                        state_d   = ST_START;
                        tx_d      = START_BIT;
                        busy_d    = 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                        tx_d      = shreg_q[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg_d = shreg_shift;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = ST_STOP;
                            tx_d    = STOP_BIT;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                            tx_d      = shreg_shift[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        done_d = 1'b1;
                        if (tx_start) begin
                            shreg_d   = tx_data;
                            bit_idx_d = '0;
                            state_d   = ST_START;
                            tx_d      = START_BIT;
                            busy_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = IDLE_LINE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = IDLE_LINE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LINE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: stimulus queues expected words, an independent
// line monitor decodes each frame and compares it bit-for-bit and in timing.
module tb_serial_tx_piso;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int FRAME  = (DATA_W + 2) * CPB;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_tx_piso #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic expected_line(input int c, input logic [DATA_W-1:0] w);
        if (c < CPB) return 1'b0;
        if (c < CPB * (DATA_W + 1)) return w[c / CPB - 1];
        return 1'b1;
    endfunction

    // Line monitor: counts enabled edges from the start bit and checks every sample.
    initial begin
        bit in_frame = 1'b0;
        int c = 0;
        logic [DATA_W-1:0] w = '0;
        logic edge_en, edge_rst;
        forever begin
            @(posedge clk);
            edge_en  = en;
            edge_rst = reset;
            #1;
            if (edge_rst) begin
                in_frame = 1'b0;
                checkOutput("reset_tx", tx, 1);
                checkOutput("reset_busy", busy, 0);
                checkOutput("reset_done", done, 0);
            end else if (edge_en) begin
                if (in_frame) begin
                    c++;
                    if (c == FRAME) begin
                        checkOutput("done_at_frame_end", done, 1);
                        if (tx === 1'b1) checkOutput("busy_after_frame", busy, 0);
                        in_frame = 1'b0;
                    end else begin
                        checkOutput("done_mid_frame", done, 0);
                        checkOutput("busy_mid_frame", busy, 1);
                        checkOutput("tx_bit", tx, expected_line(c, w));
                    end
                end else begin
                    checkOutput("done_idle", done, 0);
                end
                if (!in_frame && tx === 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_frame: got start bit, expected idle line at %0t", $time);
                        w = '0;
                    end else begin
                        w = exp_q.pop_front();
                    end
                    in_frame = 1'b1;
                    c = 0;
                    checkOutput("busy_at_start", busy, 1);
                end
            end else if (in_frame) begin
                checkOutput("tx_frozen", tx, expected_line(c, w));
                checkOutput("busy_frozen", busy, 1);
            end
        end
    end

    // Present a word for one accepting edge; returns just after that edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] data);
        @(negedge clk);
        exp_q.push_back(data);
        tx_start = 1'b1;
        tx_data  = data;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) return;
        end
        errors++;
        checks++;
        $display("[TB] FAIL %s: got no done pulse, expected one within 200 clocks", name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end before 200000 ns");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, n2;
        reset    = 1'b1;
        en       = 1'b1;
        tx_start = 1'b0;
        tx_data  = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en       = 1'($urandom);
            tx_start = 1'($urandom);
            tx_data  = DATA_W'($urandom);
        end
        @(negedge clk);
        reset    = 1'b0;
        en       = 1'b1;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);

        applyStimulus(8'hA5);
        wait_done("single_done", n);
        checkOutput("single_frame_len", n, 40);
        repeat (3) @(negedge clk);

        // tx_start stays high across the first frame's end.
        @(negedge clk);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        wait_done("b2b_first_done", n);
        checkOutput("b2b_first_len", n, 40);
        @(negedge clk);
        tx_start = 1'b0;
        n2 = 1;
        wait_done("b2b_second_done", n);
        checkOutput("b2b_done_spacing", n + n2 - 1, 40);
        repeat (3) @(negedge clk);

        applyStimulus(8'h96);
        repeat (17) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_done("stall_done", n);
        checkOutput("stall_frame_len", 17 + 5 + n, 45);
        repeat (3) @(negedge clk);

        applyStimulus(8'h81);
        repeat (9) @(posedge clk);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_start = 1'b0;
        wait_done("ignore_done", n);
        checkOutput("ignore_frame_len", 10 + n, 40);
        repeat (50) @(negedge clk);
        checkOutput("ignore_busy_idle", busy, 0);

        applyStimulus(8'hE7);
        repeat (16) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_tx", tx, 1);
        checkOutput("midreset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(8'h5A);
        wait_done("after_reset_done", n);
        checkOutput("after_reset_len", n, 40);

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
